// File: rtl/sq_pkg.sv
// Shared types and sizing helpers for the sequential squarer.
package sq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sq_state_t;

  localparam int SQ_DEFAULT_WIDTH = 4;
  localparam int SQ_CNT_W         = $clog2(SQ_DEFAULT_WIDTH);

  function automatic int result_width(input int w);
    return 2 * w;
  endfunction

  // Bit-step counter only ever holds WIDTH-1 .. 0.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sq_abs.sv
// Conditional two's-complement negate producing the operand magnitude.
// For the most negative input the WIDTH-bit result reads as 2^(WIDTH-1) unsigned.
module sq_abs #(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] mag
);

  always_comb begin
    mag = a;
    if ((SIGNED != 0) && a[WIDTH-1]) mag = -a;
  end

endmodule

// File: rtl/seq_squarer.sv
// Multi-cycle shift-add squarer with valid/ready on both sides.
// Build option SQ_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// CALC  | one multiplier bit consumed per clock, busy high
// DONE  | result on D, out_valid high until out_ready
module seq_squarer
  import sq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                A,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [result_width(WIDTH)-1:0]  D,
  output logic                            busy
);

  localparam int RW = result_width(WIDTH);
  localparam int CW = cnt_width(WIDTH);

  sq_state_t        state, state_nxt;
  logic [RW-1:0]    acc, mcand, acc_nxt;
  logic [WIDTH-1:0] mult, mult_shift, mag;
  logic [CW-1:0]    cnt;
  logic             calc_last;

  sq_abs #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_abs (
    .a   (A),
    .mag (mag)
  );

  assign acc_nxt    = mult[0] ? (acc + mcand) : acc;
  assign mult_shift = mult >> 1;

`ifdef SQ_EARLY_TERM_EN
  assign calc_last = (cnt == '0) || (mult_shift == '0);
`else
  assign calc_last = (cnt == '0);
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (calc_last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      mcand <= '0;
      mult  <= '0;
      cnt   <= '0;
      D     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= {{WIDTH{1'b0}}, mag};
            mult  <= mag;
            acc   <= '0;
            cnt   <= CW'(WIDTH - 1);
          end
        end
        CALC: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          mult  <= mult_shift;
          cnt   <= cnt - 1'b1;
          if (calc_last) D <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
